// File: rtl/ctrl_pipe_pkg.sv
// rtl/ctrl_pipe_pkg.sv - shared constants, stage names and stage action decode for ctrl_pipe
package ctrl_pipe_pkg;

   localparam int DEF_WIDTH  = 17;
   localparam int DEF_STAGES = 3;
   localparam int DEF_CNT_W  = 16;

   // Stage indices for the default three-deep pipe
   localparam int STG_E = 0;
   localparam int STG_M = 1;
   localparam int STG_W = 2;

   // What a stage register does on the coming edge
   typedef enum logic [1:0] {
      ACT_LOAD   = 2'd0,
      ACT_FLUSH  = 2'd1,
      ACT_HOLD   = 2'd2,
      ACT_BUBBLE = 2'd3
   } stage_act_e;

   // Squash beats hold, hold beats bubble; a bubble is inserted when the
   // upstream stage is frozen so its word is not copied downstream twice.
   function automatic stage_act_e stage_action(input logic squash,
                                               input logic hold,
                                               input logic hold_prev);
      stage_act_e act;
      if (squash) begin
         act = ACT_FLUSH;
      end else if (hold) begin
         act = ACT_HOLD;
      end else if (hold_prev) begin
         act = ACT_BUBBLE;
      end else begin
         act = ACT_LOAD;
      end
      return act;
   endfunction

endpackage

// File: rtl/ctrl_pipe_stage.sv
// rtl/ctrl_pipe_stage.sv - one control-pipeline stage register with squash/hold/bubble/load priority
module ctrl_pipe_stage
   import ctrl_pipe_pkg::*;
#(
   parameter int              WIDTH = DEF_WIDTH,
   parameter logic [WIDTH-1:0] KEEP  = '1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             squash,
   input  logic             hold,
   input  logic             hold_prev,
   input  logic             src_valid,
   input  logic [WIDTH-1:0] src_word,
   output logic             valid,
   output logic [WIDTH-1:0] word
);

   logic             valid_q, valid_d;
   logic [WIDTH-1:0] word_q, word_d;
   stage_act_e       act;

   // Next-state selection in priority order; an empty slot always carries word 0
   always_comb begin
      act     = stage_action(squash, hold, hold_prev);
      valid_d = valid_q;
      word_d  = word_q;
      case (act)
         ACT_FLUSH, ACT_BUBBLE: begin
            valid_d = 1'b0;
            word_d  = '0;
         end
         ACT_HOLD: begin
            valid_d = valid_q;
            word_d  = word_q;
         end
         ACT_LOAD: begin
            valid_d = src_valid;
            word_d  = src_valid ? (src_word & KEEP) : '0;
         end
         default: begin
            valid_d = 1'b0;
            word_d  = '0;
         end
      endcase
   end

   // Stage register, cleared at once by the active-low reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= 1'b0;
         word_q  <= '0;
      end else begin
         valid_q <= valid_d;
         word_q  <= word_d;
      end
   end

   assign valid = valid_q;
   assign word  = word_q;

endmodule

// File: rtl/ctrl_pipe.sv
// rtl/ctrl_pipe.sv - parameterised stall/flush control pipeline with stage-0 stall counter
module ctrl_pipe
   import ctrl_pipe_pkg::*;
#(
   parameter int                       WIDTH     = DEF_WIDTH,
   parameter int                       STAGES    = DEF_STAGES,
   parameter int                       CNT_W     = DEF_CNT_W,
   parameter logic [STAGES*WIDTH-1:0]  KEEP_MASK = '1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [WIDTH-1:0]        in_ctrl,
   input  logic                    in_valid,
   input  logic [STAGES-1:0]       stall,
   input  logic [STAGES-1:0]       flush,
   input  logic                    flush_all,
   input  logic                    clr_cnt,
   output logic [STAGES*WIDTH-1:0] out_ctrl,
   output logic [STAGES-1:0]       out_valid,
   output logic [CNT_W-1:0]        stall_cnt
);

   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic             src_valid;
      logic [WIDTH-1:0] src_word;
      logic             hold_prev;

      if (k == 0) begin : g_head
         assign src_valid = in_valid;
         assign src_word  = in_ctrl;
         assign hold_prev = 1'b0;
      end else begin : g_body
         assign src_valid = out_valid[k-1];
         assign src_word  = out_ctrl[(k-1)*WIDTH +: WIDTH];
         assign hold_prev = stall[k-1];
      end

      ctrl_pipe_stage #(
         .WIDTH (WIDTH),
         .KEEP  (KEEP_MASK[k*WIDTH +: WIDTH])
      ) u_stage (
         .clk       (clk),
         .rst       (rst),
         .squash    (flush_all | flush[k]),
         .hold      (stall[k]),
         .hold_prev (hold_prev),
         .src_valid (src_valid),
         .src_word  (src_word),
         .valid     (out_valid[k]),
         .word      (out_ctrl[k*WIDTH +: WIDTH])
      );
   end

   // Count cycles where the head stage is frozen on a real instruction; saturating, clear wins
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (clr_cnt) begin
         stall_cnt_d = '0;
      end else if (stall[STG_E] && out_valid[STG_E] && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   // Stall counter register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb/tb_ctrl_pipe.sv - directed and randomized self-checking bench for ctrl_pipe
module tb_ctrl_pipe;

   logic        clk;
   logic        rst;
   logic [16:0] in_ctrl;
   logic        in_valid;
   logic [2:0]  stall;
   logic [2:0]  flush;
   logic        flush_all;
   logic        clr_cnt;

   logic [50:0] out_ctrl_a, out_ctrl_b;
   logic [2:0]  out_valid_a, out_valid_b;
   logic [15:0] stall_cnt_a;
   logic [3:0]  stall_cnt_b;

   int checks   = 0;
   int failures = 0;

   // reference state: one valid bit and one word per stage for each instance
   logic        mv[3];
   logic [16:0] mwa[3];
   logic [16:0] mwb[3];
   logic [16:0] mask_a[3];
   logic [16:0] mask_b[3];
   int          mcnt_a;
   int          mcnt_b;

   ctrl_pipe dut_a (
      .clk       (clk),
      .rst       (rst),
      .in_ctrl   (in_ctrl),
      .in_valid  (in_valid),
      .stall     (stall),
      .flush     (flush),
      .flush_all (flush_all),
      .clr_cnt   (clr_cnt),
      .out_ctrl  (out_ctrl_a),
      .out_valid (out_valid_a),
      .stall_cnt (stall_cnt_a)
   );

   ctrl_pipe #(
      .CNT_W     (4),
      .KEEP_MASK ({17'h0000F, {34{1'b1}}})
   ) dut_b (
      .clk       (clk),
      .rst       (rst),
      .in_ctrl   (in_ctrl),
      .in_valid  (in_valid),
      .stall     (stall),
      .flush     (flush),
      .flush_all (flush_all),
      .clr_cnt   (clr_cnt),
      .out_ctrl  (out_ctrl_b),
      .out_valid (out_valid_b),
      .stall_cnt (stall_cnt_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         mv[k]  = 1'b0;
         mwa[k] = '0;
         mwb[k] = '0;
      end
      mcnt_a = 0;
      mcnt_b = 0;
   endtask

   // Apply the stage rules to the whole pipe at once using the old contents
   task automatic model_step();
      logic        nv[3];
      logic [16:0] na[3];
      logic [16:0] nb[3];
      logic        sv;
      logic [16:0] sa, sb;
      for (int k = 0; k < 3; k++) begin
         sv = (k == 0) ? in_valid : mv[k-1];
         sa = (k == 0) ? in_ctrl  : mwa[k-1];
         sb = (k == 0) ? in_ctrl  : mwb[k-1];
         if (flush_all || flush[k]) begin
            nv[k] = 1'b0; na[k] = '0; nb[k] = '0;
         end else if (stall[k]) begin
            nv[k] = mv[k]; na[k] = mwa[k]; nb[k] = mwb[k];
         end else if (k > 0 && stall[k-1]) begin
            nv[k] = 1'b0; na[k] = '0; nb[k] = '0;
         end else begin
            nv[k] = sv;
            na[k] = sv ? (sa & mask_a[k]) : 17'h0;
            nb[k] = sv ? (sb & mask_b[k]) : 17'h0;
         end
      end
      if (clr_cnt) begin
         mcnt_a = 0;
         mcnt_b = 0;
      end else if (stall[0] && mv[0]) begin
         mcnt_a = (mcnt_a < 65535) ? mcnt_a + 1 : 65535;
         mcnt_b = (mcnt_b < 15) ? mcnt_b + 1 : 15;
      end
      for (int k = 0; k < 3; k++) begin
         mv[k]  = nv[k];
         mwa[k] = na[k];
         mwb[k] = nb[k];
      end
   endtask

   task automatic check_model(input string tag);
      check({tag, "_ctrl_a"},  64'(out_ctrl_a),  64'({mwa[2], mwa[1], mwa[0]}));
      check({tag, "_valid_a"}, 64'(out_valid_a), 64'({mv[2], mv[1], mv[0]}));
      check({tag, "_cnt_a"},   64'(stall_cnt_a), 64'(mcnt_a));
      check({tag, "_ctrl_b"},  64'(out_ctrl_b),  64'({mwb[2], mwb[1], mwb[0]}));
      check({tag, "_valid_b"}, 64'(out_valid_b), 64'({mv[2], mv[1], mv[0]}));
      check({tag, "_cnt_b"},   64'(stall_cnt_b), 64'(mcnt_b));
   endtask

   // Drive one cycle of inputs, clock it, then compare against the reference
   task automatic step(input string tag, input logic iv, input logic [16:0] ic,
                       input logic [2:0] st, input logic [2:0] fl,
                       input logic fa, input logic cl);
      in_valid  = iv;
      in_ctrl   = ic;
      stall     = st;
      flush     = fl;
      flush_all = fa;
      clr_cnt   = cl;
      model_step();
      @(posedge clk);
      #1;
      check_model(tag);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ctrl_a"},  64'(out_ctrl_a),  64'h0);
      check({tag, "_valid_a"}, 64'(out_valid_a), 64'h0);
      check({tag, "_cnt_a"},   64'(stall_cnt_a), 64'h0);
      check({tag, "_ctrl_b"},  64'(out_ctrl_b),  64'h0);
      check({tag, "_cnt_b"},   64'(stall_cnt_b), 64'h0);
   endtask

   initial begin
      logic [2:0] rs, rf;
      for (int k = 0; k < 3; k++) begin
         mask_a[k] = 17'h1FFFF;
         mask_b[k] = 17'h1FFFF;
      end
      mask_b[2] = 17'h0000F;

      rst = 1'b0; in_ctrl = '0; in_valid = 1'b0; stall = '0; flush = '0;
      flush_all = 1'b0; clr_cnt = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b1;

      // single word walks E -> M -> W, one cycle each
      step("walk1", 1'b1, 17'h1ABCD, 3'b000, 3'b000, 1'b0, 1'b0);
      check("walk1_s0", 64'(out_ctrl_a[16:0]), 64'h1ABCD);
      check("walk1_v",  64'(out_valid_a), 64'b001);
      step("walk2", 1'b0, 17'h00000, 3'b000, 3'b000, 1'b0, 1'b0);
      check("walk2_s1", 64'(out_ctrl_a[33:17]), 64'h1ABCD);
      check("walk2_v",  64'(out_valid_a), 64'b010);
      step("walk3", 1'b0, 17'h00000, 3'b000, 3'b000, 1'b0, 1'b0);
      check("walk3_s2", 64'(out_ctrl_a[50:34]), 64'h1ABCD);
      check("walk3_v",  64'(out_valid_a), 64'b100);
      step("walk4", 1'b0, 17'h00000, 3'b000, 3'b000, 1'b0, 1'b0);
      check("walk4_v",  64'(out_valid_a), 64'b000);

      // head stall for two cycles: hold, bubble behind, count 2
      step("st0_load", 1'b1, 17'h01234, 3'b000, 3'b000, 1'b0, 1'b0);
      step("st0_a", 1'b1, 17'h05555, 3'b001, 3'b000, 1'b0, 1'b0);
      check("st0_a_bubble", 64'(out_valid_a[1]), 64'h0);
      step("st0_b", 1'b1, 17'h05555, 3'b001, 3'b000, 1'b0, 1'b0);
      check("st0_b_hold", 64'(out_ctrl_a[16:0]), 64'h01234);
      check("st0_b_bubble", 64'(out_ctrl_a[33:17]), 64'h0);
      check("st0_cnt", 64'(stall_cnt_a), 64'd2);

      // flush beats stall on stage 0, stage 1 holds
      step("fl_f0", 1'b1, 17'h00AAA, 3'b000, 3'b000, 1'b0, 1'b1);
      step("fl_f1", 1'b1, 17'h00BBB, 3'b000, 3'b000, 1'b0, 1'b0);
      step("fl_f2", 1'b1, 17'h00CCC, 3'b000, 3'b000, 1'b0, 1'b0);
      step("fl_sq", 1'b1, 17'h00DDD, 3'b011, 3'b001, 1'b0, 1'b0);
      check("fl_sq_s0v", 64'(out_valid_a[0]), 64'h0);
      check("fl_sq_s1",  64'(out_ctrl_a[33:17]), 64'h00BBB);

      // exception squash of a full pipe
      step("fa_f0", 1'b1, 17'h11111, 3'b000, 3'b000, 1'b0, 1'b0);
      step("fa_f1", 1'b1, 17'h12222, 3'b000, 3'b000, 1'b0, 1'b0);
      step("fa_f2", 1'b1, 17'h13333, 3'b000, 3'b000, 1'b0, 1'b0);
      step("fa_sq", 1'b1, 17'h14444, 3'b000, 3'b000, 1'b1, 1'b0);
      check("fa_v", 64'(out_valid_a), 64'h0);
      check("fa_w", 64'(out_ctrl_a), 64'h0);

      // retention mask on stage 2 of the second instance
      step("km0", 1'b1, 17'h1FFFF, 3'b000, 3'b000, 1'b0, 1'b0);
      step("km1", 1'b0, 17'h00000, 3'b000, 3'b000, 1'b0, 1'b0);
      step("km2", 1'b0, 17'h00000, 3'b000, 3'b000, 1'b0, 1'b0);
      check("km_s2", 64'(out_ctrl_b[50:34]), 64'h0000F);

      // 4-bit counter saturation, then clear wins over a counted stall
      step("sat_ld", 1'b1, 17'h07777, 3'b000, 3'b000, 1'b0, 1'b1);
      for (int i = 0; i < 20; i++) begin
         step("sat_st", 1'b1, 17'h00001, 3'b001, 3'b000, 1'b0, 1'b0);
      end
      check("sat_b", 64'(stall_cnt_b), 64'hF);
      check("sat_a", 64'(stall_cnt_a), 64'd20);
      step("sat_clr", 1'b1, 17'h00001, 3'b001, 3'b000, 1'b0, 1'b1);
      check("sat_clr_a", 64'(stall_cnt_a), 64'd0);
      check("sat_clr_b", 64'(stall_cnt_b), 64'd0);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         rs = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
         rf = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'b000;
         step("rnd", 1'($urandom), 17'($urandom), rs, rf,
              ($urandom_range(0, 31) == 0), ($urandom_range(0, 63) == 0));
      end

      // asynchronous reset in the middle of a stall
      step("ar_ld", 1'b1, 17'h0F0F0, 3'b000, 3'b000, 1'b0, 1'b0);
      step("ar_st", 1'b1, 17'h0F0F1, 3'b011, 3'b000, 1'b0, 1'b0);
      #2;
      rst = 1'b0;
      #1;
      check_all_zero("async_rst");
      model_reset();
      @(posedge clk);
      #1;
      check_all_zero("rst_held");
      rst = 1'b1;
      for (int i = 0; i < 60; i++) begin
         rs = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
         step("post_rst", 1'b1, 17'($urandom), rs, 3'b000, 1'b0, 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ctrl_pipe.md
CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 Parameter WIDTH, default 17, SHALL set the control-word width carried per stage.
REQ-002 Parameter STAGES, default 3 (E, M, W), SHALL set the pipeline depth; legal range 1..8.
REQ-003 Parameter CNT_W, default 16, SHALL set the stall-counter width.
REQ-004 Parameter KEEP_MASK, default all ones, width STAGES*WIDTH, SHALL give the per-stage field retention mask; slice k is [k*WIDTH +: WIDTH].
REQ-005 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1 bit, SHALL be the reset, asynchronous and active-low.
REQ-007 Port in_ctrl, input, WIDTH bits, SHALL be the decode-stage control word.
REQ-008 Port in_valid, input, 1 bit, SHALL mark in_ctrl as a real instruction.
REQ-009 Port stall, input, STAGES bits, SHALL be the per-stage hold request; bit k is stage k.
REQ-010 Port flush, input, STAGES bits, SHALL be the per-stage squash request.
REQ-011 Port flush_all, input, 1 bit, SHALL be the exception squash of every stage.
REQ-012 Port clr_cnt, input, 1 bit, SHALL synchronously clear the stall counter.
REQ-013 Port out_ctrl, output, STAGES*WIDTH bits, SHALL give the registered word of stage k at [k*WIDTH +: WIDTH].
REQ-014 Port out_valid, output, STAGES bits, SHALL give the registered valid bit of each stage.
REQ-015 Port stall_cnt, output, CNT_W bits, SHALL count the cycles in which stage 0 holds a valid instruction while stalled.

Function
REQ-016 Stage 0 source SHALL be {in_valid, in_ctrl}; stage k>0 source SHALL be stage k-1's registered {valid, word}.
REQ-017 Each stage SHALL apply this per-cycle priority: flush_all > flush[k] > stall[k] > bubble > load.
REQ-018 flush_all or flush[k] SHALL load word 0 and valid 0.
REQ-019 stall[k], absent any flush, SHALL hold the stage's word and valid unchanged.
REQ-020 Bubble (k>0 only): when stall[k-1]=1, stall[k]=0 and no flush applies, stage k SHALL load word 0 and valid 0, so no instruction is duplicated.
REQ-021 Load SHALL store valid = source valid and word = source word & KEEP_MASK slice k; when source valid=0, word SHALL be stored as 0.
REQ-022 With no stalls or flushes, in_ctrl SHALL appear on stage k output k+1 cycles after it is presented.
REQ-023 Outputs SHALL be purely registered, with no combinational path from inputs to out_ctrl or out_valid.
REQ-024 The stall counter SHALL increment when stall[0]=1 and out_valid[0]=1, and SHALL saturate at all-ones.
REQ-025 clr_cnt SHALL take priority over increment and set the counter to 0.
REQ-026 A stall on a stage with valid=0 SHALL be legal, hold zero, and not count.
REQ-027 Stalls on multiple non-adjacent stages SHALL each be resolved independently by REQ-017.

Reset
REQ-028 rst=0 SHALL immediately clear all out_ctrl, out_valid and stall_cnt to 0, regardless of clk.
REQ-029 Reset asserted mid-stall or mid-flush SHALL discard all held state; the first load occurs on the first rising edge after rst returns to 1.

Structure
REQ-030 Package ctrl_pipe_pkg SHALL hold the default WIDTH/STAGES/CNT_W constants and the stage-index names (STG_E=0, STG_M=1, STG_W=2).
REQ-031 Sub-module ctrl_pipe_stage SHALL implement one stage register with the REQ-017 priority and SHALL be generated STAGES times.
REQ-032 The stall counter SHALL live in the top level.

Verification
REQ-033 Defaults, in_ctrl=17'h1ABCD with in_valid=1 for one cycle, no stalls -> stage 0/1/2 outputs show 17'h1ABCD at cycles +1/+2/+3, each for exactly one cycle.
REQ-034 stall=3'b001 for 2 cycles with a valid word in stage 0 -> stage 0 holds, stage 1 shows word 0 and valid 0 for 2 cycles, and stall_cnt=2.
REQ-035 stall=3'b011 together with flush=3'b001 -> stage 0 cleared (flush beats stall), and stage 1 holds.
REQ-036 Pipe full of valid words, flush_all pulse -> out_valid=3'b000 and all words 0 on the next edge.
REQ-037 KEEP_MASK slice 2 = 17'h0000F, in_ctrl=17'h1FFFF -> stage 2 word = 17'h0000F.
REQ-038 CNT_W=4, 20 counted stall cycles -> stall_cnt=4'hF; then clr_cnt together with stall -> 0; then rst low mid-run -> all outputs 0 asynchronously.
